// File: rtl/keypad_scanner.sv
// keypad_scanner: matrix keypad scanner with per-frame debounce.
// Drives the columns with a rotating one-cold pattern, samples the rows in the
// last dwell cycle of each column, classifies every frame as NONE / ONE(code) /
// MULTI, and emits press/release events once a result has been stable for
// DEBOUNCE consecutive frames.
// Ports:
//   cclk        clock, rising edge
//   rst         synchronous active-high reset
//   kypd_row    row lines (active-low, externally pulled up)
//   kypd_col    column drive, active-low, at most one bit low
//   key_code    code of the last accepted key (held after release)
//   key_valid   one-cycle pulse on a newly accepted key
//   key_release one-cycle pulse when the held key is accepted as released
//   key_held    high while an accepted key is down
module keypad_scanner #(
  parameter int unsigned N_ROWS   = 4,
  parameter int unsigned N_COLS   = 4,
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned HEX_MAP  = 1,
  parameter int unsigned CODE_W   = (N_ROWS * N_COLS > 1) ? $clog2(N_ROWS * N_COLS) : 1
) (
  input  logic              cclk,
  input  logic              rst,
  input  logic [N_ROWS-1:0] kypd_row,
  output logic [N_COLS-1:0] kypd_col,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_release,
  output logic              key_held
);

  localparam int unsigned ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int unsigned COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
  // Legacy front-panel layout, nibble index = row*4 + col.
  localparam logic [63:0] HEX_LUT = 64'hDEF0_C987_B654_A321;

  typedef enum logic {ST_SCAN, ST_EVAL} state_t;
  typedef enum logic [1:0] {RES_NONE, RES_ONE, RES_MULTI} res_t;

  state_t              state_q, state_d;
  logic                run_q, run_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [DIV_W-1:0]    dwell_q, dwell_d;
  logic                acc_any_q, acc_any_d;
  logic                acc_multi_q, acc_multi_d;
  logic [ROW_W-1:0]    acc_row_q, acc_row_d;
  logic [COL_W-1:0]    acc_col_q, acc_col_d;
  res_t                prev_res_q, prev_res_d;
  logic [CODE_W-1:0]   prev_code_q, prev_code_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [N_COLS-1:0]   kypd_col_d;
  logic [CODE_W-1:0]   key_code_d;
  logic                key_valid_d, key_release_d, key_held_d;

  logic                row_any, row_multi;
  logic [ROW_W-1:0]    row_idx;
  res_t                frame_res;
  logic [CODE_W-1:0]   frame_code;
  logic                same;

  // Translate a (row, col) hit into the reported key code.
  function automatic logic [CODE_W-1:0] map_code(input logic [ROW_W-1:0] r,
                                                 input logic [COL_W-1:0] c);
    logic [63:0] lut;
    if (HEX_MAP != 0) begin
      lut = HEX_LUT >> (32'(r) * 32'd16 + 32'(c) * 32'd4);
      return CODE_W'(lut[3:0]);
    end
    return CODE_W'(32'(r) * N_COLS + 32'(c));
  endfunction

  // Classify the current row sample: any row low, more than one low, which row.
  always_comb begin
    row_any   = 1'b0;
    row_multi = 1'b0;
    row_idx   = '0;
    for (int i = 0; i < int'(N_ROWS); i++) begin
      if (!kypd_row[i]) begin
        if (row_any) row_multi = 1'b1;
        row_any = 1'b1;
        row_idx = ROW_W'(i);
      end
    end
  end

  // Next-state, frame accumulation, debounce and event generation.
  always_comb begin
    state_d       = state_q;
    run_d         = 1'b1;
    col_d         = col_q;
    dwell_d       = dwell_q;
    acc_any_d     = acc_any_q;
    acc_multi_d   = acc_multi_q;
    acc_row_d     = acc_row_q;
    acc_col_d     = acc_col_q;
    prev_res_d    = prev_res_q;
    prev_code_d   = prev_code_q;
    cnt_d         = cnt_q;
    key_code_d    = key_code;
    key_valid_d   = 1'b0;
    key_release_d = 1'b0;
    key_held_d    = key_held;
    frame_res     = RES_NONE;
    frame_code    = '0;
    same          = 1'b0;

    case (state_q)
      ST_SCAN: begin
        // The first cycle out of reset is idle so column 0 gets a full dwell.
        if (run_q) begin
          if (dwell_q == DIV_W'(SCAN_DIV - 1)) begin
            dwell_d = '0;
            // A second low row, or a hit in a second column, makes the frame MULTI.
            if (row_multi || (row_any && acc_any_q)) acc_multi_d = 1'b1;
            if (row_any && !acc_any_q) begin
              acc_any_d = 1'b1;
              acc_row_d = row_idx;
              acc_col_d = col_q;
            end
            if (col_q == COL_W'(N_COLS - 1)) begin
              col_d   = '0;
              state_d = ST_EVAL;
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else begin
            dwell_d = dwell_q + DIV_W'(1);
          end
        end
      end

      ST_EVAL: begin
        frame_res  = acc_multi_q ? RES_MULTI : (acc_any_q ? RES_ONE : RES_NONE);
        frame_code = map_code(acc_row_q, acc_col_q);
        same       = (frame_res == prev_res_q) &&
                     ((frame_res != RES_ONE) || (frame_code == prev_code_q));
        if (same) begin
          if (cnt_q != CNT_W'(DEBOUNCE)) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d       = CNT_W'(1);
          prev_res_d  = frame_res;
          prev_code_d = frame_code;
        end
        // Act only on the frame that first reaches the stability threshold.
        if ((cnt_d == CNT_W'(DEBOUNCE)) && !(same && (cnt_q == CNT_W'(DEBOUNCE)))) begin
          if ((frame_res == RES_ONE) && (!key_held || (key_code != frame_code))) begin
            key_valid_d = 1'b1;
            key_code_d  = frame_code;
            key_held_d  = 1'b1;
          end else if ((frame_res == RES_NONE) && key_held) begin
            key_release_d = 1'b1;
            key_held_d    = 1'b0;
          end
        end
        acc_any_d   = 1'b0;
        acc_multi_d = 1'b0;
        acc_row_d   = '0;
        acc_col_d   = '0;
        col_d       = '0;
        dwell_d     = '0;
        state_d     = ST_SCAN;
      end

      default: state_d = ST_SCAN;
    endcase

    kypd_col_d = (state_d == ST_SCAN) ? ~(N_COLS'(1) << col_d) : '1;
  end

  // State and output registers.
  always_ff @(posedge cclk) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      run_q       <= 1'b0;
      col_q       <= '0;
      dwell_q     <= '0;
      acc_any_q   <= 1'b0;
      acc_multi_q <= 1'b0;
      acc_row_q   <= '0;
      acc_col_q   <= '0;
      prev_res_q  <= RES_NONE;
      prev_code_q <= '0;
      cnt_q       <= '0;
      kypd_col    <= '1;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      key_held    <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      col_q       <= col_d;
      dwell_q     <= dwell_d;
      acc_any_q   <= acc_any_d;
      acc_multi_q <= acc_multi_d;
      acc_row_q   <= acc_row_d;
      acc_col_q   <= acc_col_d;
      prev_res_q  <= prev_res_d;
      prev_code_q <= prev_code_d;
      cnt_q       <= cnt_d;
      kypd_col    <= kypd_col_d;
      key_code    <= key_code_d;
      key_valid   <= key_valid_d;
      key_release <= key_release_d;
      key_held    <= key_held_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner (4x4, SCAN_DIV=4,
// DEBOUNCE=2, hex map). A keypad model pulls a row low only while its column is
// driven low; key presses change only at frame boundaries, and a frame-level
// reference model (history of frame results) predicts events.
module tb_keypad_scanner;

  localparam int DEB    = 2;
  localparam int FRAME  = 17;
  localparam int R_NONE = 16;
  localparam int R_MULT = 17;

  logic       cclk;
  logic       rst;
  logic [3:0] kypd_row;
  logic [3:0] kypd_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_release;
  logic       key_held;

  keypad_scanner #(
    .N_ROWS(4), .N_COLS(4), .SCAN_DIV(4), .DEBOUNCE(DEB), .HEX_MAP(1), .CODE_W(4)
  ) dut (
    .cclk(cclk), .rst(rst), .kypd_row(kypd_row), .kypd_col(kypd_col),
    .key_code(key_code), .key_valid(key_valid), .key_release(key_release),
    .key_held(key_held)
  );

  initial cclk = 1'b0;
  always #5 cclk = ~cclk;

  // press[r][c]: key at row r, column c is physically closed.
  logic [3:0] press [4];
  always_comb begin
    for (int r = 0; r < 4; r++) kypd_row[r] = ~|(press[r] & ~kypd_col);
  end

  // Front-panel legend, [row][col].
  int hex_tab [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};

  int n_checks = 0;
  int n_fail   = 0;

  int         hist[$];
  logic       m_held;
  logic [3:0] m_code;
  int         e_v, e_r;
  logic [15:0] obs_vec, exp_vec;
  int          tot_v, tot_r;

  function automatic int frame_result();
    int n = 0;
    int code = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press[r][c]) begin
          n++;
          code = hex_tab[r][c];
        end
    if (n == 0) return R_NONE;
    if (n > 1) return R_MULT;
    return code;
  endfunction

  // Accept a result when the last DEB frames agree and the frame before differed.
  task automatic model_eval(input int res);
    bit stable, fresh;
    hist.push_back(res);
    if (hist.size() > DEB + 1) void'(hist.pop_front());
    e_v = 0;
    e_r = 0;
    if (hist.size() >= DEB) begin
      stable = 1'b1;
      for (int i = hist.size() - DEB; i < hist.size(); i++) if (hist[i] != res) stable = 1'b0;
      fresh = (hist.size() == DEB) || (hist[0] != res);
      if (stable && fresh) begin
        if (res < 16 && (!m_held || m_code != 4'(res))) begin
          e_v = 1; m_code = 4'(res); m_held = 1'b1;
        end else if (res == R_NONE && m_held) begin
          e_r = 1; m_held = 1'b0;
        end
      end
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_held = 1'b0;
    m_code = 4'h0;
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 4; r++) press[r] = 4'h0;
  endtask

  // Run one frame from a frame start; gather observed and predicted summaries.
  task automatic step_frame();
    int vc = 0;
    int rc = 0;
    for (int i = 1; i <= FRAME; i++) begin
      @(posedge cclk); #1;
      vc += int'(key_valid);
      rc += int'(key_release);
    end
    model_eval(frame_result());
    obs_vec = {4'(vc), 4'(rc), key_valid, key_release, key_held, 1'b0, key_code};
    exp_vec = {4'(e_v), 4'(e_r), e_v != 0, e_r != 0, m_held, 1'b0, m_code};
    tot_v += vc;
    tot_r += rc;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge cclk);
    #1 rst = 1'b0;
    @(posedge cclk); #1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [3:0] one = 4'b0001;
    logic [3:0] exp_col;
    clear_keys();
    rst = 1'b1;
    repeat (3) @(posedge cclk);
    #1;
    n_checks++;
    if ({kypd_col, key_code, key_valid, key_release, key_held} !== {4'hF, 4'h0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_values: col/code/v/r/held got %b/%h/%b/%b/%b want 1111/0/0/0/0",
               kypd_col, key_code, key_valid, key_release, key_held);
    end
    rst = 1'b0;
    n_checks++;
    if (kypd_col !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_release_col: got %b want 1111", kypd_col);
    end
    for (int i = 0; i < FRAME + 1; i++) begin
      @(posedge cclk); #1;
      exp_col = (i == FRAME - 1) ? 4'hF : ~(one << ((i % FRAME) / 4));
      n_checks++;
      if (kypd_col !== exp_col) begin
        n_fail++;
        $display("FAIL col_sequence cycle %0d: got %b want %b", i, kypd_col, exp_col);
      end
    end
    apply_reset();
  endtask

  task automatic test_press();
    press[2] = 4'b0010;
    tot_v = 0; tot_r = 0;
    for (int f = 0; f < 4; f++) begin
      step_frame();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL press frame %0d: {vcnt,rcnt,v,r,held,0,code} got %h want %h", f, obs_vec, exp_vec);
      end
    end
    n_checks++;
    if (tot_v != 1 || key_code !== 4'h8 || key_held !== 1'b1) begin
      n_fail++;
      $display("FAIL press_result: pulses %0d code %h held %b want 1 8 1", tot_v, key_code, key_held);
    end
  endtask

  task automatic test_release();
    clear_keys();
    tot_v = 0; tot_r = 0;
    for (int f = 0; f < 3; f++) begin
      step_frame();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL release frame %0d: {vcnt,rcnt,v,r,held,0,code} got %h want %h", f, obs_vec, exp_vec);
      end
    end
    n_checks++;
    if (tot_r != 1 || tot_v != 0 || key_held !== 1'b0 || key_code !== 4'h8) begin
      n_fail++;
      $display("FAIL release_result: rel %0d val %0d held %b code %h want 1 0 0 8", tot_r, tot_v, key_held, key_code);
    end
  endtask

  task automatic test_bounce();
    tot_v = 0; tot_r = 0;
    for (int f = 0; f < 6; f++) begin
      press[0] = (f % 2 == 0) ? 4'b1000 : 4'b0000;
      step_frame();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL bounce frame %0d: {vcnt,rcnt,v,r,held,0,code} got %h want %h", f, obs_vec, exp_vec);
      end
    end
    n_checks++;
    if (tot_v != 0) begin
      n_fail++;
      $display("FAIL bounce_no_valid: got %0d pulses want 0", tot_v);
    end
    press[0] = 4'b1000;
    for (int f = 0; f < 2; f++) step_frame();
    n_checks++;
    if (obs_vec !== exp_vec || tot_v != 1 || key_code !== 4'hA) begin
      n_fail++;
      $display("FAIL bounce_steady: vec %h want %h, pulses %0d code %h want 1 a", obs_vec, exp_vec, tot_v, key_code);
    end
    clear_keys();
    for (int f = 0; f < 3; f++) step_frame();
  endtask

  task automatic test_chord();
    int phase_keys [4] = '{4'b0001, 4'b0001, 4'b0101, 4'b0001};
    int phase_row1 [4] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
    for (int p = 0; p < 4; p++) begin
      press[0] = 4'(phase_keys[p]);
      press[1] = 4'(phase_row1[p]);
      tot_v = 0; tot_r = 0;
      for (int f = 0; f < 3; f++) begin
        step_frame();
        n_checks++;
        if (obs_vec !== exp_vec) begin
          n_fail++;
          $display("FAIL chord phase %0d frame %0d: {vcnt,rcnt,v,r,held,0,code} got %h want %h", p, f, obs_vec, exp_vec);
        end
      end
      // Only phase 1 (plain key 1) produces an event; chords and the return are silent.
      n_checks++;
      if (tot_v != ((p == 1) ? 1 : 0) || tot_r != 0) begin
        n_fail++;
        $display("FAIL chord_events phase %0d: valid %0d release %0d", p, tot_v, tot_r);
      end
    end
    n_checks++;
    if (key_held !== 1'b1 || key_code !== 4'h1) begin
      n_fail++;
      $display("FAIL chord_hold: held %b code %h want 1 1", key_held, key_code);
    end
    clear_keys();
    for (int f = 0; f < 3; f++) step_frame();
  endtask

  task automatic test_back_to_back();
    int k;
    int rel_seen = 0;
    press[1] = 4'b0010;
    for (int f = 0; f < 3; f++) step_frame();
    n_checks++;
    if (key_held !== 1'b1 || key_code !== 4'h5) begin
      n_fail++;
      $display("FAIL hold5: held %b code %h want 1 5", key_held, key_code);
    end
    k = int'($urandom_range(1, 15));
    repeat (k) begin
      @(posedge cclk); #1;
      rel_seen += int'(key_release);
    end
    rst = 1'b1;
    repeat (2) begin
      @(posedge cclk); #1;
      rel_seen += int'(key_release);
    end
    n_checks++;
    if ({kypd_col, key_code, key_valid, key_release, key_held} !== {4'hF, 4'h0, 3'b000} || rel_seen != 0) begin
      n_fail++;
      $display("FAIL midframe_reset: col %b code %h v %b r %b held %b rel %0d", kypd_col, key_code,
               key_valid, key_release, key_held, rel_seen);
    end
    rst = 1'b0;
    @(posedge cclk); #1;
    model_reset();
    tot_v = 0; tot_r = 0;
    for (int f = 0; f < 3; f++) begin
      step_frame();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL reaccept frame %0d: {vcnt,rcnt,v,r,held,0,code} got %h want %h", f, obs_vec, exp_vec);
      end
    end
    press[1] = 4'b0000;
    press[2] = 4'b0100;
    for (int f = 0; f < 3; f++) begin
      step_frame();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL direct_change frame %0d: {vcnt,rcnt,v,r,held,0,code} got %h want %h", f, obs_vec, exp_vec);
      end
    end
    n_checks++;
    if (tot_v != 2 || tot_r != 0 || key_code !== 4'h9 || key_held !== 1'b1) begin
      n_fail++;
      $display("FAIL direct_change_result: valid %0d rel %0d code %h held %b want 2 0 9 1", tot_v, tot_r, key_code, key_held);
    end
    clear_keys();
    for (int f = 0; f < 3; f++) step_frame();
  endtask

  task automatic test_random();
    int nk, nf;
    for (int e = 0; e < 25; e++) begin
      clear_keys();
      nk = int'($urandom_range(0, 2));
      for (int j = 0; j < nk; j++) press[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
      nf = int'($urandom_range(1, 3));
      for (int f = 0; f < nf; f++) begin
        step_frame();
        n_checks++;
        if (obs_vec !== exp_vec) begin
          n_fail++;
          $display("FAIL random ep %0d frame %0d: {vcnt,rcnt,v,r,held,0,code} got %h want %h", e, f, obs_vec, exp_vec);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_keys();
    model_reset();
    tot_v = 0;
    tot_r = 0;
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_chord();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
